// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq
// Registered constant source for the handshake fabric: each accepted control
// token yields one output token carrying the next entry of a constant table.
// The table is walked cyclically (WRAP=1) or saturates on its last entry
// (WRAP=0). A one-slot output register cuts the control-to-data path.

module handshake_constant_seq #(
   parameter int unsigned              DATA_WIDTH = 32,
   parameter int unsigned              DEPTH      = 4,
   parameter logic [DATA_WIDTH*DEPTH-1:0] VALUES  = '0,
   parameter bit                       WRAP       = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic                  full_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] entry;
   logic                  acc;
   logic                  emit;

   // Slot can take a new token when empty or when it drains this cycle.
   assign ctrl_ready = !full_q || outs_ready;
   assign acc        = ctrl_valid && ctrl_ready;
   assign emit       = full_q && outs_ready;
   assign outs       = data_q;
   assign outs_valid = full_q;

   // Table lookup as a compare-mux so a non-power-of-two DEPTH never indexes out of range.
   always_comb begin
      entry = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (idx_q == IDX_W'(i)) begin
            entry = VALUES[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Output slot and table index; reset overrides any same-cycle accept/emit.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
         idx_q  <= '0;
      end else if (acc) begin
         data_q <= entry;
         full_q <= 1'b1;
         if (idx_q == LAST_IDX) begin
            idx_q <= WRAP ? '0 : LAST_IDX;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end else if (emit) begin
         full_q <= 1'b0;
      end
   end

endmodule
